// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: redirect FSM encoding, PC step and reset defaults.
package cpu_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } fru_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Signal bundle between branch/jump/hazard logic, instruction memory and the fetch redirect unit.
interface fetch_redirect_unit_if #(
    parameter int CNT_W = 16
);
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [31:0]       jump_target;
    logic              stall;
    logic              imem_ready;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic              pending;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output branch_taken, branch_target, jump, jump_target, stall, imem_ready,
        input  pc, pc_plus4, flush_if_id, flush_id_ex, flush_ex_mem, pending, redirect_cnt
    );

    modport slave (
        input  branch_taken, branch_target, jump, jump_target, stall, imem_ready,
        output pc, pc_plus4, flush_if_id, flush_id_ex, flush_ex_mem, pending, redirect_cnt
    );
endinterface

// File: rtl/fetch_redirect_unit_pc_next_mux.sv
// Combinational next-PC selection: redirect priority, pending target reuse, stall/hold and sequential step.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic        i_pending,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_stall,
    input  logic        i_imem_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pend_target,
    output logic [31:0] o_next_pc,
    output logic        o_redirect_valid,
    output logic        o_req,
    output logic [31:0] o_req_target
);

    logic [31:0] w_eff_target;

    always_comb begin
        o_req            = i_branch_taken | i_jump;
        o_req_target     = i_branch_taken ? i_branch_target : i_jump_target;
        w_eff_target     = o_req ? o_req_target : i_pend_target;
        o_next_pc        = i_pc;
        o_redirect_valid = 1'b0;

        // A redirect (new or held) commits only when imem takes the address; stall never blocks it.
        if (i_pending || o_req) begin
            if (i_imem_ready) begin
                o_next_pc        = w_eff_target;
                o_redirect_valid = 1'b1;
            end
        end else if (!i_stall && i_imem_ready) begin
            o_next_pc = i_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Owns the fetch PC: selects the next address, squashes wrong-path stages and holds redirects until imem accepts.
module fetch_redirect_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_redirect_unit_if.slave  bus
);

    fru_state_e       r_state;
    fru_state_e       w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_pend_target;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_next_pc;
    logic             w_redirect_valid;
    logic             w_req;
    logic [31:0]      w_req_target;
    logic             w_pending;

    assign w_pending = (r_state == PENDING);

    pc_next_mux u_pc_next_mux (
        .i_pending        (w_pending),
        .i_branch_taken   (bus.branch_taken),
        .i_branch_target  (bus.branch_target),
        .i_jump           (bus.jump),
        .i_jump_target    (bus.jump_target),
        .i_stall          (bus.stall),
        .i_imem_ready     (bus.imem_ready),
        .i_pc             (r_pc),
        .i_pend_target    (r_pend_target),
        .o_next_pc        (w_next_pc),
        .o_redirect_valid (w_redirect_valid),
        .o_req            (w_req),
        .o_req_target     (w_req_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (w_req && !bus.imem_ready) w_state_nxt = PENDING;
            PENDING: if (bus.imem_ready)           w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // The latest request always wins the held target, whichever state we are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_pend_target <= 32'h0;
            r_cnt         <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_req) begin
                r_pend_target <= w_req_target;
            end
            if (w_redirect_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.pc           = r_pc;
    assign bus.pc_plus4     = r_pc + PC_STEP;
    assign bus.flush_if_id  = rst_n & (bus.branch_taken | bus.jump | w_pending);
    assign bus.flush_id_ex  = rst_n & bus.branch_taken;
    assign bus.flush_ex_mem = rst_n & bus.branch_taken;
    assign bus.pending      = rst_n & w_pending;
    assign bus.redirect_cnt = r_cnt;

endmodule
